// File: rtl/game_sprite_mover.sv
// Per-sprite motion controller: owns the sprite position, steps it by a
// signed velocity every STEP_FRAMES frames, waits out the display's
// registered on-screen feedback and reports when the sprite leaves the screen.
// Optional build macro GAME_SPRITE_MOVER_BOUNCE_EN: bounce off the screen edges
// instead of exiting.
module game_sprite_mover #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int D_WIDTH       = 4,
    parameter int STEP_FRAMES   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_strobe,
    input  logic                      write_xy,
    input  logic [X_WIDTH-1:0]        new_x,
    input  logic [Y_WIDTH-1:0]        new_y,
    input  logic                      write_dxy,
    input  logic signed [D_WIDTH-1:0] new_dx,
    input  logic signed [D_WIDTH-1:0] new_dy,
    input  logic                      enable_update,
    input  logic                      sprite_within_screen,
    output logic [X_WIDTH-1:0]        sprite_x,
    output logic [Y_WIDTH-1:0]        sprite_y,
    output logic                      moving,
    output logic                      exited,
    output logic                      stopped
);

    localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(STEP_FRAMES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SETTLE, ST_EXITED} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [X_WIDTH-1:0]         r_x;
    logic [Y_WIDTH-1:0]         r_y;
    logic signed [D_WIDTH-1:0]  r_dx;
    logic signed [D_WIDTH-1:0]  r_dy;
    logic [CNT_W-1:0]           r_frame_cnt;
    logic                       r_settle_cnt;
    logic                       r_moving;
    logic                       r_exited;
    logic                       r_stopped;
    logic                       w_count_frame;
    logic                       w_step;

    // Position plus sign-extended velocity, wrapping modulo 2^width.
    function automatic logic [X_WIDTH-1:0] wrap_add_x(input logic [X_WIDTH-1:0] pos,
                                                      input logic signed [D_WIDTH-1:0] d);
        return pos + {{(X_WIDTH-D_WIDTH){d[D_WIDTH-1]}}, d};
    endfunction

    function automatic logic [Y_WIDTH-1:0] wrap_add_y(input logic [Y_WIDTH-1:0] pos,
                                                      input logic signed [D_WIDTH-1:0] d);
        return pos + {{(Y_WIDTH-D_WIDTH){d[D_WIDTH-1]}}, d};
    endfunction

`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
    // True when the step would leave [0, SCREEN_WIDTH-SPRITE_WIDTH]; one extra
    // bit keeps the sign of the candidate position.
    function automatic logic x_out_of_range(input logic [X_WIDTH-1:0] pos,
                                            input logic signed [D_WIDTH-1:0] d);
        logic signed [X_WIDTH:0] nxt;
        nxt = $signed({1'b0, pos}) + $signed({{(X_WIDTH+1-D_WIDTH){d[D_WIDTH-1]}}, d});
        return (nxt < 0) || (nxt > $signed((X_WIDTH+1)'(SCREEN_WIDTH - SPRITE_WIDTH)));
    endfunction

    function automatic logic y_out_of_range(input logic [Y_WIDTH-1:0] pos,
                                            input logic signed [D_WIDTH-1:0] d);
        logic signed [Y_WIDTH:0] nxt;
        nxt = $signed({1'b0, pos}) + $signed({{(Y_WIDTH+1-D_WIDTH){d[D_WIDTH-1]}}, d});
        return (nxt < 0) || (nxt > $signed((Y_WIDTH+1)'(SCREEN_HEIGHT - SPRITE_HEIGHT)));
    endfunction

    logic w_x_bounce;
    logic w_y_bounce;
    assign w_x_bounce = x_out_of_range(r_x, r_dx);
    assign w_y_bounce = y_out_of_range(r_y, r_dy);
`endif

    // A frame only counts while running and enabled; a load always wins over a step.
    assign w_count_frame = (r_state == ST_RUN) && frame_strobe && enable_update && !write_xy;
    assign w_step        = w_count_frame && (r_frame_cnt == LAST_FRAME);

    assign sprite_x = r_x;
    assign sprite_y = r_y;
    assign moving   = r_moving;
    assign exited   = r_exited;
    assign stopped  = r_stopped;

    // Next-state decode; the on-screen feedback is looked at only on the last settle cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (write_xy) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (enable_update) w_state_nxt = ST_RUN;
                ST_RUN:    if (w_step) w_state_nxt = ST_SETTLE;
                ST_SETTLE: if (r_settle_cnt) begin
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
                    w_state_nxt = ST_RUN;
`else
                    w_state_nxt = sprite_within_screen ? ST_RUN : ST_EXITED;
`endif
                end
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // FSM state, settle timer and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 1'b0;
            r_moving     <= 1'b0;
            r_exited     <= 1'b0;
            r_stopped    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= (r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE);
            r_moving     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_SETTLE);
            r_exited     <= (r_state == ST_SETTLE) && (w_state_nxt == ST_EXITED);
            r_stopped    <= (w_state_nxt == ST_EXITED);
        end
    end

    // Frame divider: cleared by a load, frozen while paused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (write_xy) begin
            r_frame_cnt <= '0;
        end else if (w_count_frame) begin
            r_frame_cnt <= (r_frame_cnt == LAST_FRAME) ? '0 : r_frame_cnt + CNT_W'(1);
        end
    end

    // Position and velocity registers; loads take priority over stepping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_dx <= '0;
            r_dy <= '0;
        end else begin
            if (write_xy) begin
                r_x <= new_x;
                r_y <= new_y;
            end else if (w_step) begin
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
                if (!w_x_bounce) r_x <= wrap_add_x(r_x, r_dx);
                if (!w_y_bounce) r_y <= wrap_add_y(r_y, r_dy);
`else
                r_x <= wrap_add_x(r_x, r_dx);
                r_y <= wrap_add_y(r_y, r_dy);
`endif
            end
            if (write_dxy) begin
                r_dx <= new_dx;
                r_dy <= new_dy;
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
            end else if (w_step) begin
                if (w_x_bounce) r_dx <= -r_dx;
                if (w_y_bounce) r_dy <= -r_dy;
`endif
            end
        end
    end

endmodule

// File: tb/tb_game_sprite_mover.sv
// Directed bench for game_sprite_mover: one instance with STEP_FRAMES=1 and one
// with STEP_FRAMES=4 share all inputs; expected values are hand-computed.
module tb_game_sprite_mover;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_strobe = 1'b0;
    logic              write_xy = 1'b0;
    logic [9:0]        new_x = '0;
    logic [9:0]        new_y = '0;
    logic              write_dxy = 1'b0;
    logic signed [3:0] new_dx = '0;
    logic signed [3:0] new_dy = '0;
    logic              enable_update = 1'b0;
    logic              sprite_within_screen = 1'b1;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic       mov_a, exi_a, stp_a, mov_b, exi_b, stp_b;

    int n_cmp = 0;
    int n_err = 0;
    int exit_cnt_a = 0;
    int exit_base;

    always #5 clk = ~clk;

    game_sprite_mover u_dut (
        .clk(clk), .reset(reset), .frame_strobe(frame_strobe),
        .write_xy(write_xy), .new_x(new_x), .new_y(new_y),
        .write_dxy(write_dxy), .new_dx(new_dx), .new_dy(new_dy),
        .enable_update(enable_update), .sprite_within_screen(sprite_within_screen),
        .sprite_x(x_a), .sprite_y(y_a), .moving(mov_a), .exited(exi_a), .stopped(stp_a)
    );

    game_sprite_mover #(.STEP_FRAMES(4)) u_dut4 (
        .clk(clk), .reset(reset), .frame_strobe(frame_strobe),
        .write_xy(write_xy), .new_x(new_x), .new_y(new_y),
        .write_dxy(write_dxy), .new_dx(new_dx), .new_dy(new_dy),
        .enable_update(enable_update), .sprite_within_screen(sprite_within_screen),
        .sprite_x(x_b), .sprite_y(y_b), .moving(mov_b), .exited(exi_b), .stopped(stp_b)
    );

    always @(posedge clk) if (exi_a) exit_cnt_a <= exit_cnt_a + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int x, input int y, input int dx, input int dy);
        write_xy  = 1'b1;
        write_dxy = 1'b1;
        new_x  = 10'(x);
        new_y  = 10'(y);
        new_dx = 4'(dx);
        new_dy = 4'(dy);
        tick(1);
        write_xy  = 1'b0;
        write_dxy = 1'b0;
    endtask

    // Strobe edge plus the two settle cycles, leaving the mover back in RUN.
    task automatic strobe_step();
        frame_strobe = 1'b1;
        tick(1);
        frame_strobe = 1'b0;
        tick(2);
    endtask

    initial begin
        #3;
        check_val("rst_x", int'(x_a), 0);
        check_val("rst_y", int'(y_a), 0);
        check_val("rst_moving", int'(mov_a), 0);
        check_val("rst_exited", int'(exi_a), 0);
        check_val("rst_stopped", int'(stp_a), 0);
        tick(2);
        reset = 1'b0;

        // Basic motion, STEP_FRAMES=1
        load(100, 50, 2, -1);
        check_val("load_x", int'(x_a), 100);
        check_val("load_y", int'(y_a), 50);
        check_val("load_idle", int'(mov_a), 0);
        enable_update = 1'b1;
        tick(1);
        check_val("run_moving", int'(mov_a), 1);
        exit_base = exit_cnt_a;
        repeat (3) strobe_step();
        check_val("t1_x", int'(x_a), 106);
        check_val("t1_y", int'(y_a), 47);
        check_val("t1_moving", int'(mov_a), 1);
        check_val("t1_no_exit", exit_cnt_a - exit_base, 0);

        // Frame divider and pause
        load(200, 100, 1, 0);
        tick(1);
        repeat (8) strobe_step();
        check_val("div_x4", int'(x_b), 202);
        check_val("div_x1", int'(x_a), 208);
        enable_update = 1'b0;
        repeat (4) strobe_step();
        check_val("pause_x4", int'(x_b), 202);
        check_val("pause_x1", int'(x_a), 208);
        check_val("pause_moving", int'(mov_b), 1);
        enable_update = 1'b1;
        repeat (3) strobe_step();
        check_val("held_cnt_x4", int'(x_b), 202);
        strobe_step();
        check_val("resume_x4", int'(x_b), 203);
        check_val("resume_x1", int'(x_a), 212);

`ifndef GAME_SPRITE_MOVER_BOUNCE_EN
        // Exit off the right edge
        load(636, 100, 4, 0);
        tick(1);
        exit_base = exit_cnt_a;
        frame_strobe = 1'b1;
        tick(1);
        frame_strobe = 1'b0;
        check_val("edge_x", int'(x_a), 640);
        sprite_within_screen = 1'b0;
        tick(1);
        check_val("settle1_exited", int'(exi_a), 0);
        check_val("settle1_moving", int'(mov_a), 1);
        tick(1);
        check_val("exit_pulse", int'(exi_a), 1);
        check_val("exit_stopped", int'(stp_a), 1);
        check_val("exit_moving", int'(mov_a), 0);
        tick(1);
        check_val("exit_pulse_end", int'(exi_a), 0);
        repeat (2) strobe_step();
        check_val("exit_hold_x", int'(x_a), 640);
        check_val("exit_hold_stop", int'(stp_a), 1);
        check_val("exit_once", exit_cnt_a - exit_base, 1);

        // Wrap-around exit, then reload out of EXITED
        sprite_within_screen = 1'b1;
        load(2, 100, -3, 0);
        check_val("reload_stopped", int'(stp_a), 0);
        tick(1);
        frame_strobe = 1'b1;
        tick(1);
        frame_strobe = 1'b0;
        check_val("wrap_x", int'(x_a), 1023);
        sprite_within_screen = 1'b0;
        tick(2);
        check_val("wrap_stopped", int'(stp_a), 1);
        check_val("wrap_hold_x", int'(x_a), 1023);
        sprite_within_screen = 1'b1;
        load(10, 10, 1, 1);
        check_val("leave_exit_stop", int'(stp_a), 0);
        check_val("leave_exit_mov", int'(mov_a), 0);
        check_val("leave_exit_x", int'(x_a), 10);
        tick(1);
        strobe_step();
        check_val("after_exit_x", int'(x_a), 11);
        check_val("after_exit_y", int'(y_a), 11);
        check_val("after_exit_mov", int'(mov_a), 1);
`else
        // Bounce off the right edge; feedback low must not cause an exit
        load(630, 100, 4, 0);
        tick(1);
        exit_base = exit_cnt_a;
        sprite_within_screen = 1'b0;
        strobe_step();
        check_val("bounce_hold_x", int'(x_a), 630);
        check_val("bounce_moving", int'(mov_a), 1);
        strobe_step();
        check_val("bounce_back_x", int'(x_a), 626);
        check_val("bounce_no_exit", exit_cnt_a - exit_base, 0);
        check_val("bounce_not_stop", int'(stp_a), 0);
        sprite_within_screen = 1'b1;
`endif

        // Load on the same edge as a step-triggering strobe
        frame_strobe = 1'b1;
        write_xy  = 1'b1;
        write_dxy = 1'b1;
        new_x  = 10'd300;
        new_y  = 10'd200;
        new_dx = 4'sd2;
        new_dy = 4'sd2;
        tick(1);
        frame_strobe = 1'b0;
        write_xy  = 1'b0;
        write_dxy = 1'b0;
        check_val("prio_x", int'(x_a), 300);
        check_val("prio_y", int'(y_a), 200);
        check_val("prio_idle", int'(mov_a), 0);
        tick(1);
        strobe_step();
        check_val("prio_dx_x", int'(x_a), 302);
        check_val("prio_dy_y", int'(y_a), 202);

        // Asynchronous reset in the middle of SETTLE
        frame_strobe = 1'b1;
        tick(1);
        frame_strobe = 1'b0;
        check_val("pre_rst_x", int'(x_a), 304);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_x", int'(x_a), 0);
        check_val("async_rst_y", int'(y_a), 0);
        check_val("async_rst_mov", int'(mov_a), 0);
        tick(1);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
